// File: rtl/contra_pkg.sv
// Shared definitions for the playfield logic.
//   enemy_state_t : per-slot life-cycle state (DEAD, ALIVE, FLASH, EXPLODE)
//   SCREEN_W/H    : visible playfield size; coordinates outside it are parked
//   SCORE_MAX     : score saturation value
//   abs_diff      : |a-b| of two 10-bit coordinates, formed as an 11-bit signed
//                   difference so the result never wraps
//   bullet_live   : a bullet is live only while its centre is on screen
package contra_pkg;

  typedef enum logic [1:0] {
    DEAD    = 2'd0,
    ALIVE   = 2'd1,
    FLASH   = 2'd2,
    EXPLODE = 2'd3
  } enemy_state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int SCORE_MAX = 9999;
  localparam int COORD_W   = 10;
  localparam int N_BULLET  = 5;
  localparam int SCORE_W   = 14;

  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    // Operands are at most 1023, so the difference fits in 11-bit signed.
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 11'(-d) : 11'(d);
  endfunction

  function automatic logic bullet_live(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
  endfunction

endpackage

// File: rtl/enemy_hit_fsm.sv
// Life cycle of one enemy slot: hit points, flash/explode timer, kill pulse.
//   frame_clk, Reset : frame clock, synchronous active-high reset
//   play             : when low, state, HP and timer hold and no kill is raised
//   spawn            : one-frame spawn request, honoured only while DEAD
//   hit              : one or more bullets struck this slot this frame
//   state            : registered slot state (also serves as debug view)
//   kill             : registered one-frame pulse on entry to EXPLODE
//   kill_next        : combinational kill decision, lets the top level update
//                      the score on the same edge as the kill pulse
module enemy_hit_fsm
  import contra_pkg::*;
#(
  parameter int ENEMY_HP       = 3,
  parameter int FLASH_FRAMES   = 4,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         play,
  input  logic         spawn,
  input  logic         hit,
  output enemy_state_t state,
  output logic         kill,
  output logic         kill_next
);

  localparam int T_MAX = (FLASH_FRAMES > EXPLODE_FRAMES) ? FLASH_FRAMES : EXPLODE_FRAMES;
  localparam int TMR_W = $clog2(T_MAX + 1);

  enemy_state_t     state_q, state_d;
  logic [2:0]       hp_q, hp_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             kill_q, kill_d;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    timer_d = timer_q;
    kill_d  = 1'b0;
    if (play) begin
      case (state_q)
        DEAD: begin
          if (spawn) begin
            state_d = ALIVE;
            hp_d    = 3'(ENEMY_HP);
            timer_d = '0;
          end
        end
        ALIVE: begin
          // Several simultaneous bullets still cost only one hit point.
          if (hit) begin
            timer_d = '0;
            if (hp_q > 3'd1) begin
              hp_d    = hp_q - 3'd1;
              state_d = FLASH;
            end else begin
              hp_d    = 3'd0;
              state_d = EXPLODE;
              kill_d  = 1'b1;
            end
          end
        end
        FLASH: begin
          // Timer reads 0 on the entry edge, so FLASH spans FLASH_FRAMES frames.
          if (timer_q == TMR_W'(FLASH_FRAMES - 1)) begin
            state_d = ALIVE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        EXPLODE: begin
          if (timer_q == TMR_W'(EXPLODE_FRAMES - 1)) begin
            state_d = DEAD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = DEAD;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= DEAD;
      hp_q    <= '0;
      timer_q <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      timer_q <= timer_d;
      kill_q  <= kill_d;
    end
  end

  assign state     = state_q;
  assign kill      = kill_q;
  assign kill_next = kill_d;

endmodule

// File: rtl/bullet_hit_detect.sv
// Tests five player bullets against N_ENEMY hitboxes each frame, drives the
// per-slot life-cycle FSMs and keeps the saturating score.
//   frame_clk, Reset      : frame clock, synchronous active-high reset
//   play                  : game running; low freezes everything, pulses 0
//   bX..b4Y               : bullet 0..4 centre coordinates (10 bits each)
//   enemyX, enemyY        : packed enemy centres, slot 0 in the LSBs
//   enemy_spawn           : per-slot one-frame spawn request
//   enemy_state           : packed per-slot state, 2 bits each
//   bullet_hit            : one-frame pulse per bullet that struck an ALIVE slot
//   enemy_kill            : one-frame pulse per slot entering EXPLODE
//   score                 : binary score, saturating at 9999
module bullet_hit_detect
  import contra_pkg::*;
#(
  parameter int N_ENEMY        = 4,
  parameter int ENEMY_HP       = 3,
  parameter int HIT_W          = 8,
  parameter int HIT_H          = 12,
  parameter int FLASH_FRAMES   = 4,
  parameter int EXPLODE_FRAMES = 16,
  parameter int SCORE_PER_KILL = 100
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   play,
  input  logic [9:0]             bX,
  input  logic [9:0]             bY,
  input  logic [9:0]             b1X,
  input  logic [9:0]             b1Y,
  input  logic [9:0]             b2X,
  input  logic [9:0]             b2Y,
  input  logic [9:0]             b3X,
  input  logic [9:0]             b3Y,
  input  logic [9:0]             b4X,
  input  logic [9:0]             b4Y,
  input  logic [N_ENEMY*10-1:0]  enemyX,
  input  logic [N_ENEMY*10-1:0]  enemyY,
  input  logic [N_ENEMY-1:0]     enemy_spawn,
  output logic [N_ENEMY*2-1:0]   enemy_state,
  output logic [4:0]             bullet_hit,
  output logic [N_ENEMY-1:0]     enemy_kill,
  output logic [13:0]            score
);

  enemy_state_t         slot_state [N_ENEMY];
  logic [N_ENEMY-1:0]   slot_hit;
  logic [N_ENEMY-1:0]   kill_next;
  logic [9:0]           bx [N_BULLET];
  logic [9:0]           by [N_BULLET];
  logic                 found;
  logic [4:0]           bullet_hit_q, bullet_hit_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W:0]     score_sum;
  int                   kills;

  // Overlap array with lowest-index priority: each bullet claims at most one
  // slot, but every bullet that claims a slot is pulsed.
  always_comb begin
    bx[0] = bX;  by[0] = bY;
    bx[1] = b1X; by[1] = b1Y;
    bx[2] = b2X; by[2] = b2Y;
    bx[3] = b3X; by[3] = b3Y;
    bx[4] = b4X; by[4] = b4Y;
    bullet_hit_d = '0;
    slot_hit     = '0;
    found        = 1'b0;
    for (int b = 0; b < N_BULLET; b++) begin
      found = 1'b0;
      for (int j = 0; j < N_ENEMY; j++) begin
        if (play && !found && bullet_live(bx[b], by[b]) && (slot_state[j] == ALIVE) &&
            (abs_diff(bx[b], enemyX[j*COORD_W +: COORD_W]) <= 11'(HIT_W)) &&
            (abs_diff(by[b], enemyY[j*COORD_W +: COORD_W]) <= 11'(HIT_H))) begin
          found           = 1'b1;
          bullet_hit_d[b] = 1'b1;
          slot_hit[j]     = 1'b1;
        end
      end
    end
  end

  // Score grows by SCORE_PER_KILL per kill this frame, summed one bit wider
  // than the register and then clamped.
  always_comb begin
    kills = 0;
    for (int j = 0; j < N_ENEMY; j++) begin
      kills = kills + int'(kill_next[j]);
    end
    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(kills * SCORE_PER_KILL);
    score_d   = (score_sum > (SCORE_W + 1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
  end

  for (genvar j = 0; j < N_ENEMY; j++) begin : g_slot
    enemy_hit_fsm #(
      .ENEMY_HP       (ENEMY_HP),
      .FLASH_FRAMES   (FLASH_FRAMES),
      .EXPLODE_FRAMES (EXPLODE_FRAMES)
    ) u_fsm (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .play      (play),
      .spawn     (enemy_spawn[j]),
      .hit       (slot_hit[j]),
      .state     (slot_state[j]),
      .kill      (enemy_kill[j]),
      .kill_next (kill_next[j])
    );
    assign enemy_state[2*j +: 2] = slot_state[j];
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      bullet_hit_q <= '0;
      score_q      <= '0;
    end else begin
      bullet_hit_q <= bullet_hit_d;
      score_q      <= score_d;
    end
  end

  assign bullet_hit = bullet_hit_q;
  assign score      = score_q;

endmodule

// File: tb/tb_bullet_hit_detect.sv
// Bench for bullet_hit_detect: directed steps plus randomized frames, every
// frame checked against a frame-level reference model of the game rules.
module tb_bullet_hit_detect;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic           Reset;
  logic           play;
  logic [9:0]     bxa [5];
  logic [9:0]     bya [5];
  logic [9:0]     exa [N];
  logic [9:0]     eya [N];
  logic [N-1:0]   spawn;
  logic [N*10-1:0] enemyX, enemyY;
  logic [N*2-1:0] enemy_state;
  logic [4:0]     bullet_hit;
  logic [N-1:0]   enemy_kill;
  logic [13:0]    score;

  for (genvar j = 0; j < N; j++) begin : g_pack
    assign enemyX[j*10 +: 10] = exa[j];
    assign enemyY[j*10 +: 10] = eya[j];
  end

  bullet_hit_detect dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .play        (play),
    .bX          (bxa[0]), .bY  (bya[0]),
    .b1X         (bxa[1]), .b1Y (bya[1]),
    .b2X         (bxa[2]), .b2Y (bya[2]),
    .b3X         (bxa[3]), .b3Y (bya[3]),
    .b4X         (bxa[4]), .b4Y (bya[4]),
    .enemyX      (enemyX),
    .enemyY      (enemyY),
    .enemy_spawn (spawn),
    .enemy_state (enemy_state),
    .bullet_hit  (bullet_hit),
    .enemy_kill  (enemy_kill),
    .score       (score)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [30:0] exp_q[$];   // {state[7:0], hit[4:0], kill[3:0], score[13:0]}

  // Reference model: per slot state number, hit points, frames remaining.
  int m_st  [N];
  int m_hp  [N];
  int m_rem [N];
  int m_score;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [4:0]   eh;
    logic [N-1:0] ek;
    logic [N-1:0] sh;
    logic [7:0]   es;
    int k, dx, dy;
    bit found;
    eh = '0; ek = '0; sh = '0; es = '0; k = 0;
    if (Reset) begin
      for (int j = 0; j < N; j++) begin
        m_st[j] = 0; m_hp[j] = 0; m_rem[j] = 0;
      end
      m_score = 0;
    end else if (play) begin
      for (int b = 0; b < 5; b++) begin
        if (bxa[b] < 640 && bya[b] < 480) begin
          found = 0;
          for (int j = 0; j < N; j++) begin
            if (!found && m_st[j] == 1) begin
              dx = int'(bxa[b]) - int'(exa[j]);
              dy = int'(bya[b]) - int'(eya[j]);
              if (dx < 0) dx = -dx;
              if (dy < 0) dy = -dy;
              if (dx <= 8 && dy <= 12) begin
                found = 1; eh[b] = 1'b1; sh[j] = 1'b1;
              end
            end
          end
        end
      end
      for (int j = 0; j < N; j++) begin
        case (m_st[j])
          0: if (spawn[j]) begin m_st[j] = 1; m_hp[j] = 3; end
          1: if (sh[j]) begin
               if (m_hp[j] > 1) begin
                 m_hp[j]--; m_st[j] = 2; m_rem[j] = 4;
               end else begin
                 m_hp[j] = 0; m_st[j] = 3; m_rem[j] = 16; ek[j] = 1'b1; k++;
               end
             end
          2: begin m_rem[j]--; if (m_rem[j] == 0) m_st[j] = 1; end
          3: begin m_rem[j]--; if (m_rem[j] == 0) m_st[j] = 0; end
          default: ;
        endcase
      end
      m_score = m_score + 100 * k;
      if (m_score > 9999) m_score = 9999;
    end
    for (int j = 0; j < N; j++) es[2*j +: 2] = 2'(m_st[j]);
    exp_q.push_back({es, eh, ek, 14'(m_score)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [30:0] e;
    @(posedge frame_clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    chk("enemy_state", 32'(enemy_state), 32'(e[30:23]));
    chk("bullet_hit",  32'(bullet_hit),  32'(e[22:18]));
    chk("enemy_kill",  32'(enemy_kill),  32'(e[17:14]));
    chk("score",       32'(score),       32'(e[13:0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic park_all();
    for (int b = 0; b < 5; b++) begin
      bxa[b] = 10'd1023; bya[b] = 10'd1023;
    end
  endtask

  task automatic wait_all_dead();
    for (int i = 0; i < 60 && enemy_state != '0; i++) tick();
    chk("all_dead_timeout", 32'(enemy_state), 32'd0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // Spawn slots 0..nslots-1 at spread-out positions and hold one bullet on
  // each until it has been killed and finished exploding.
  task automatic kill_round(input int nslots);
    int ox, oy;
    park_all();
    wait_all_dead();
    for (int j = 0; j < nslots; j++) begin
      exa[j] = 10'(60 + 150 * j + int'($urandom_range(0, 20)));
      eya[j] = 10'($urandom_range(40, 400));
      spawn[j] = 1'b1;
    end
    tick();
    spawn = '0;
    for (int b = 0; b < nslots; b++) begin
      ox = int'($urandom_range(0, 16)) - 8;
      oy = int'($urandom_range(0, 24)) - 12;
      bxa[b] = 10'(int'(exa[b]) + ox);
      bya[b] = 10'(int'(eya[b]) + oy);
    end
    run(30);
    park_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int ox, oy, sel, guard;
    Reset = 1'b1; play = 1'b1; spawn = '0;
    park_all();
    for (int j = 0; j < N; j++) begin exa[j] = 10'd0; eya[j] = 10'd0; end
    for (int j = 0; j < N; j++) begin m_st[j] = 0; m_hp[j] = 0; m_rem[j] = 0; end
    m_score = 0;

    run(2);
    chk("reset_state", 32'(enemy_state), 32'd0);
    chk("reset_score", 32'(score), 32'd0);
    Reset = 1'b0;

    // Single hit: slot 0 flashes for four frames then is ALIVE again.
    exa[0] = 10'd300; eya[0] = 10'd200; spawn = 4'b0001;
    tick();
    spawn = '0;
    bxa[0] = 10'd305; bya[0] = 10'd210;
    tick();
    chk("first_hit", 32'(bullet_hit), 32'b00001);
    chk("first_flash", 32'(enemy_state[1:0]), 32'd2);
    park_all();
    run(3);
    chk("still_flash", 32'(enemy_state[1:0]), 32'd2);
    tick();
    chk("back_alive", 32'(enemy_state[1:0]), 32'd1);

    // Held bullet: finish off slot 0, then a fresh slot from full HP.
    bxa[0] = 10'd300; bya[0] = 10'd200;
    run(30);
    park_all();
    wait_all_dead();
    spawn = 4'b0001;
    tick();
    spawn = '0;
    bxa[0] = 10'd300; bya[0] = 10'd200;
    run(30);
    chk("two_kills_score", 32'(score), 32'd200);
    park_all();

    // Two bullets on one slot in one frame: both pulsed, single HP lost.
    exa[1] = 10'd100; eya[1] = 10'd100; spawn = 4'b0010;
    tick();
    spawn = '0;
    bxa[0] = 10'd100; bya[0] = 10'd100;
    bxa[3] = 10'd104; bya[3] = 10'd90;
    tick();
    chk("double_hit", 32'(bullet_hit), 32'b01001);
    chk("double_no_kill", 32'(enemy_kill), 32'd0);
    park_all();
    run(5);

    // Overlapping slots 0 and 2: lowest index takes the bullet.
    exa[0] = 10'd400; eya[0] = 10'd300;
    exa[2] = 10'd405; eya[2] = 10'd305;
    spawn = 4'b0101;
    tick();
    spawn = '0;
    bxa[2] = 10'd402; bya[2] = 10'd302;
    tick();
    chk("prio_hit", 32'(bullet_hit), 32'b00100);
    chk("prio_slot0", 32'(enemy_state[1:0]), 32'd2);
    chk("prio_slot2", 32'(enemy_state[5:4]), 32'd1);
    park_all();
    run(5);

    // Off-screen bullets never hit even when the arithmetic overlaps.
    exa[3] = 10'd635; eya[3] = 10'd200; spawn = 4'b1000;
    tick();
    spawn = '0;
    bxa[4] = 10'd640; bya[4] = 10'd200;
    tick();
    chk("offscreen_x", 32'(bullet_hit), 32'd0);
    exa[3] = 10'd300; eya[3] = 10'd475;
    bxa[4] = 10'd300; bya[4] = 10'd480;
    run(2);
    chk("offscreen_y", 32'(bullet_hit), 32'd0);
    chk("offscreen_alive", 32'(enemy_state[7:6]), 32'd1);
    park_all();

    // Score accumulation up to saturation.
    do_reset();
    guard = 0;
    while (m_score < 9600 && guard < 40) begin kill_round(4); guard++; end
    guard = 0;
    while (m_score < 9900 && guard < 10) begin kill_round(1); guard++; end
    chk("score_preset", 32'(score), 32'd9900);
    kill_round(2);
    chk("score_saturated", 32'(score), 32'd9999);
    kill_round(2);
    chk("score_stays", 32'(score), 32'd9999);

    // Randomized frames: spawns, moving enemies, near/far bullets, play gaps.
    for (int f = 0; f < 400; f++) begin
      play  = ($urandom_range(0, 9) != 0);
      Reset = ($urandom_range(0, 149) == 0);
      for (int j = 0; j < N; j++) begin
        spawn[j] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) begin
          exa[j] = 10'($urandom_range(0, 700));
          eya[j] = 10'($urandom_range(0, 500));
        end
      end
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          bxa[b] = 10'd1023; bya[b] = 10'd1023;
        end else begin
          sel = int'($urandom_range(0, N - 1));
          ox  = int'($urandom_range(0, 24)) - 12;
          oy  = int'($urandom_range(0, 32)) - 16;
          bxa[b] = 10'(int'(exa[sel]) + ox);
          bya[b] = 10'(int'(eya[sel]) + oy);
        end
      end
      tick();
    end
    Reset = 1'b0; play = 1'b1; spawn = '0;
    park_all();
    do_reset();

    // play low during an overlap: nothing moves.
    exa[0] = 10'd200; eya[0] = 10'd200; spawn = 4'b0001;
    tick();
    spawn = '0;
    bxa[0] = 10'd200; bya[0] = 10'd200;
    play = 1'b0;
    run(3);
    chk("frozen_state", 32'(enemy_state), 32'd1);
    chk("frozen_hit", 32'(bullet_hit), 32'd0);
    play = 1'b1;

    // Reset mid-explosion overrides everything.
    run(11);
    chk("kill_pulse", 32'(enemy_kill), 32'b0001);
    run(3);
    chk("exploding", 32'(enemy_state[1:0]), 32'd3);
    do_reset();
    chk("rst_state", 32'(enemy_state), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_pulses", 32'({bullet_hit, enemy_kill}), 32'd0);
    park_all();
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
